// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared state encoding and constants for the MAC sequencer
package mac_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, CAPT, RESULT} state_t;
    localparam int OUT_SEL_MAX = 24;
    localparam int NTAP_W_DEF  = 6;
endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one N-tap dot product per command on the eFPGA math-block MAC
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int NTAP_W = NTAP_W_DEF
) (
    input  logic              MAC_ACC_CLK,
    input  logic              acc_ff_rstn,
    input  logic              i_start,
    output logic              o_start_ready,
    input  logic [NTAP_W-1:0] i_len_m1,
    input  logic [5:0]        i_out_sel,
    input  logic              i_rnd_en,
    input  logic              i_sat_en,
    input  logic              i_tc,
    input  logic              i_abort,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [15:0]       i_op_data,
    output logic [NTAP_W-1:0] o_coef_addr,
    input  logic [15:0]       i_coef_rdata,
    output logic [15:0]       o_mac_oper_data,
    output logic [15:0]       o_mac_coef_data,
    output logic              o_mac_clk_en,
    output logic              o_mac_acc_clear,
    output logic              o_mac_acc_rnd,
    output logic              o_mac_acc_sat,
    output logic              o_mac_tc,
    output logic [5:0]        o_mac_out_sel,
    input  logic [15:0]       i_mac_out,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [15:0]       o_res_data,
    output logic              o_busy
);
    state_t            r_state, w_state_nxt;
    logic [NTAP_W-1:0] r_tap, w_tap_nxt, r_len_m1;
    logic [5:0]        r_out_sel;
    logic              r_rnd_en, r_sat_en, r_tc;
    logic [15:0]       r_res_data;
    logic              w_start_acc, w_first;

    assign w_start_acc     = i_start && (r_state == IDLE);
    assign o_start_ready   = r_state == IDLE;
    assign o_busy          = r_state != IDLE;
    assign o_op_ready      = r_state == RUN;
    assign o_res_valid     = r_state == RESULT;
    assign o_res_data      = r_res_data;
    assign o_mac_clk_en    = o_op_ready && i_op_valid;
    assign w_first         = o_mac_clk_en && (r_tap == '0);
    assign o_mac_acc_clear = w_first && !r_rnd_en;
    assign o_mac_acc_rnd   = w_first && r_rnd_en;
    assign o_mac_out_sel   = r_out_sel;
    assign o_mac_acc_sat   = r_sat_en;
    assign o_mac_tc        = r_tc;
    assign o_mac_oper_data = i_op_data;
    assign o_mac_coef_data = i_coef_rdata;
    // The RAM has one cycle of latency, so it is addressed with the tap about to be consumed.
    assign o_coef_addr     = w_tap_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_tap_nxt   = r_tap;
        case (r_state)
            IDLE: begin
                w_tap_nxt = '0;
                if (i_start) w_state_nxt = RUN;
            end
            RUN: if (i_op_valid) begin
                w_tap_nxt = (r_tap == r_len_m1) ? '0 : r_tap + 1'b1;
                if (r_tap == r_len_m1) w_state_nxt = CAPT;
            end
            CAPT:    w_state_nxt = RESULT;
            RESULT:  if (i_res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_abort && r_state != IDLE) begin
            w_state_nxt = IDLE;
            w_tap_nxt   = '0;
        end
    end

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            r_state    <= IDLE;
            r_tap      <= '0;
            r_len_m1   <= '0;
            r_out_sel  <= '0;
            r_rnd_en   <= 1'b0;
            r_sat_en   <= 1'b0;
            r_tc       <= 1'b0;
            r_res_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tap   <= w_tap_nxt;
            if (w_start_acc) begin
                r_len_m1  <= i_len_m1;
                // Offsets past the accumulator's top window are pinned to the highest legal one.
                r_out_sel <= (i_out_sel > 6'(OUT_SEL_MAX)) ? 6'(OUT_SEL_MAX) : i_out_sel;
                r_rnd_en  <= i_rnd_en;
                r_sat_en  <= i_sat_en;
                r_tc      <= i_tc;
            end
            if (r_state == CAPT && !i_abort) r_res_data <= i_mac_out;
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: drives mac_seq_ctrl against a behavioural MAC and coefficient RAM
module tb_mac_seq_ctrl;
    import mac_ctrl_pkg::*;
    localparam int NTAP_W = 6;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic              start = 0, rnd_en = 0, sat_en = 0, tc = 0, abort = 0;
    logic              op_valid = 0, res_ready = 0;
    logic [NTAP_W-1:0] len_m1 = '0;
    logic [5:0]        out_sel = '0;
    logic [15:0]       op_data = '0;
    logic              start_ready, op_ready, res_valid, busy;
    logic              mac_clk_en, mac_acc_clear, mac_acc_rnd, mac_acc_sat, mac_tc;
    logic [NTAP_W-1:0] coef_addr;
    logic [15:0]       coef_rdata, mac_oper_data, mac_coef_data, mac_out, res_data;
    logic [5:0]        mac_out_sel;

    int          checks = 0, errors = 0, cyc = 0, rnd_cnt = 0, clr_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] coef_mem [64];
    logic [39:0] acc;

    mac_seq_ctrl #(.NTAP_W(NTAP_W)) dut (
        .MAC_ACC_CLK(clk), .acc_ff_rstn(rstn),
        .i_start(start), .o_start_ready(start_ready), .i_len_m1(len_m1),
        .i_out_sel(out_sel), .i_rnd_en(rnd_en), .i_sat_en(sat_en), .i_tc(tc),
        .i_abort(abort), .i_op_valid(op_valid), .o_op_ready(op_ready),
        .i_op_data(op_data), .o_coef_addr(coef_addr), .i_coef_rdata(coef_rdata),
        .o_mac_oper_data(mac_oper_data), .o_mac_coef_data(mac_coef_data),
        .o_mac_clk_en(mac_clk_en), .o_mac_acc_clear(mac_acc_clear),
        .o_mac_acc_rnd(mac_acc_rnd), .o_mac_acc_sat(mac_acc_sat), .o_mac_tc(mac_tc),
        .o_mac_out_sel(mac_out_sel), .i_mac_out(mac_out),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
        .o_busy(busy)
    );

    function automatic logic [39:0] mul(input logic [15:0] a, input logic [15:0] b, input logic t);
        logic signed [39:0] sa, sb;
        sa = t ? {{24{a[15]}}, a} : {24'd0, a};
        sb = t ? {{24{b[15]}}, b} : {24'd0, b};
        return sa * sb;
    endfunction

    function automatic logic [15:0] sel_out(input logic [39:0] a, input logic [5:0] os, input logic s, input logic t);
        logic signed [39:0] v;
        v = t ? ($signed(a) >>> os) : $signed(a >> os);
        if (s && t && v > 40'sd32767) return 16'h7FFF;
        if (s && t && v < -40'sd32768) return 16'h8000;
        if (s && !t && v > 40'sd65535) return 16'hFFFF;
        return v[15:0];
    endfunction

    always @(posedge clk) coef_rdata <= coef_mem[coef_addr];

    always @(posedge clk or negedge rstn)
        if (!rstn) acc <= '0;
        else if (mac_clk_en)
            acc <= (mac_acc_clear ? 40'd0 : mac_acc_rnd ? ((mac_out_sel == 0) ? 40'd0 : 40'd1 << (mac_out_sel - 1)) : acc)
                   + mul(mac_oper_data, mac_coef_data, mac_tc);

    assign mac_out = sel_out(acc, mac_out_sel, mac_acc_sat, mac_tc);

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mac_acc_rnd) rnd_cnt <= rnd_cnt + 1;
        if (mac_acc_clear) clr_cnt <= clr_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_coef(input logic [15:0] c[8]);
        for (int i = 0; i < 8; i++) coef_mem[i] = c[i];
    endtask

    task automatic start_cmd(input int n, input logic [5:0] os, input logic r, input logic s, input logic t);
        int i = 0;
        while (!start_ready && i < 60) begin tick(); i++; end
        len_m1 = NTAP_W'(n - 1); out_sel = os; rnd_en = r; sat_en = s; tc = t; start = 1;
        tick();
        start = 0;
    endtask

    task automatic feed(input logic [15:0] ops[8], input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            if (gap) begin op_valid = 0; tick(); end
            op_valid = 1; op_data = ops[k];
            tick();
        end
        op_valid = 0;
    endtask

    task automatic wait_result(output bit got);
        int i = 0;
        while (!res_valid && i < 60) begin tick(); i++; end
        got = res_valid;
    endtask

    task automatic ack;
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({start_ready, busy, res_valid, op_ready, mac_clk_en, mac_acc_clear, mac_acc_rnd} !== 7'b1000000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 1000000", {start_ready, busy, res_valid, op_ready, mac_clk_en, mac_acc_clear, mac_acc_rnd});
        end
        checks++;
        if (res_data !== 16'h0 || coef_addr !== '0) begin
            errors++; $display("FAIL reset_data: res_data %h coef_addr %0d expected 0 0", res_data, coef_addr);
        end
        checks++;
        if (mac_out_sel !== 6'd0 || mac_acc_sat !== 1'b0 || mac_tc !== 1'b0) begin
            errors++; $display("FAIL reset_cfg: out_sel %0d sat %b tc %b expected 0 0 0", mac_out_sel, mac_acc_sat, mac_tc);
        end
        @(negedge clk) rstn = 1;
        tick();
    endtask

    task automatic test_unsigned;
        bit got; int c0; logic [15:0] exp;
        set_coef('{16'd5, 16'd6, 16'd7, 16'd8, 0, 0, 0, 0});
        exp_q.push_back(16'h0046);
        c0 = clr_cnt;
        start_cmd(4, 6'd0, 0, 0, 0);
        feed('{16'd1, 16'd2, 16'd3, 16'd4, 0, 0, 0, 0}, 4, 0);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL unsigned_capt: valid %b busy %b expected 0 1 at T1+4", res_valid, busy);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1) begin
            errors++; $display("FAIL unsigned_latency: valid %b expected 1 at T1+5", res_valid);
        end
        wait_result(got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res_data !== exp) begin
            errors++; $display("FAIL unsigned_result: got %h valid %b expected %h", res_data, got, exp);
        end
        checks++;
        if (start_ready !== 1'b0 || clr_cnt - c0 != 1) begin
            errors++; $display("FAIL unsigned_ctrl: start_ready %b clears %0d expected 0 1", start_ready, clr_cnt - c0);
        end
        ack();
        checks++;
        if (busy !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL unsigned_idle: busy %b start_ready %b expected 0 1", busy, start_ready);
        end
    endtask

    task automatic test_signed;
        bit got; logic [15:0] exp;
        set_coef('{16'd3, 16'd3, 0, 0, 0, 0, 0, 0});
        exp_q.push_back(16'hFFF7);
        start_cmd(2, 6'd0, 0, 0, 1);
        feed('{16'hFFFF, 16'hFFFE, 0, 0, 0, 0, 0, 0}, 2, 0);
        wait_result(got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res_data !== exp || mac_tc !== 1'b1) begin
            errors++; $display("FAIL signed_result: got %h tc %b valid %b expected %h tc 1", res_data, mac_tc, got, exp);
        end
        ack();
    endtask

    task automatic test_round;
        bit got; int r0, c0; logic [15:0] exp;
        exp_q.push_back(16'hFFFC);
        r0 = rnd_cnt; c0 = clr_cnt;
        start_cmd(2, 6'd1, 1, 0, 1);
        feed('{16'hFFFF, 16'hFFFE, 0, 0, 0, 0, 0, 0}, 2, 0);
        wait_result(got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res_data !== exp) begin
            errors++; $display("FAIL round_result: got %h valid %b expected %h", res_data, got, exp);
        end
        checks++;
        if (rnd_cnt - r0 != 1 || clr_cnt - c0 != 0) begin
            errors++; $display("FAIL round_pins: rnd cycles %0d clear cycles %0d expected 1 0", rnd_cnt - r0, clr_cnt - c0);
        end
        ack();
    endtask

    task automatic test_sat;
        bit got; logic [15:0] exp;
        set_coef('{16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 0});
        exp_q.push_back(16'hFFFF);
        start_cmd(2, 6'd0, 0, 1, 0);
        feed('{16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 0}, 2, 0);
        wait_result(got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res_data !== exp || mac_acc_sat !== 1'b1) begin
            errors++; $display("FAIL sat_unsigned: got %h sat %b valid %b expected %h sat 1", res_data, mac_acc_sat, got, exp);
        end
        ack();
        set_coef('{16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 0});
        exp_q.push_back(16'h7FFF);
        start_cmd(2, 6'd0, 0, 1, 1);
        feed('{16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 0}, 2, 0);
        wait_result(got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res_data !== exp) begin
            errors++; $display("FAIL sat_signed: got %h valid %b expected %h", res_data, got, exp);
        end
        ack();
    endtask

    task automatic test_bubbles;
        bit got; logic [15:0] exp;
        set_coef('{16'd5, 16'd6, 16'd7, 16'd8, 0, 0, 0, 0});
        exp_q.push_back(16'h0046);
        start_cmd(4, 6'd0, 0, 0, 0);
        feed('{16'd1, 16'd2, 16'd3, 16'd4, 0, 0, 0, 0}, 4, 1);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL bubble_capt: valid %b expected 0 at T1+8", res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1) begin
            errors++; $display("FAIL bubble_latency: valid %b expected 1 at T1+9", res_valid);
        end
        wait_result(got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res_data !== exp) begin
            errors++; $display("FAIL bubble_result: got %h valid %b expected %h", res_data, got, exp);
        end
        ack();
    endtask

    task automatic test_backpressure;
        bit got; logic [15:0] exp;
        set_coef('{16'd1, 16'd1, 0, 0, 0, 0, 0, 0});
        exp_q.push_back(16'h1235);
        start_cmd(2, 6'd0, 0, 0, 0);
        feed('{16'h1234, 16'h0001, 0, 0, 0, 0, 0, 0}, 2, 0);
        wait_result(got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res_data !== exp) begin
            errors++; $display("FAIL hold_result: got %h valid %b expected %h", res_data, got, exp);
        end
        start = 1; out_sel = 6'd5; tc = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp || start_ready !== 1'b0 || mac_out_sel !== 6'd0 || mac_tc !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d: valid %b data %h start_ready %b out_sel %0d tc %b expected 1 %h 0 0 0",
                                   i, res_valid, res_data, start_ready, mac_out_sel, mac_tc, exp);
            end
        end
        start = 0; tc = 0; out_sel = 0;
        ack();
    endtask

    task automatic test_abort;
        bit got, seen; logic [15:0] exp;
        set_coef('{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8});
        start_cmd(8, 6'd0, 0, 0, 0);
        feed('{16'd10, 16'd11, 0, 0, 0, 0, 0, 0}, 2, 0);
        abort = 1; op_valid = 1; op_data = 16'd9;
        tick();
        abort = 0; op_valid = 0;
        checks++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || coef_addr !== '0) begin
            errors++; $display("FAIL abort_idle: busy %b start_ready %b coef_addr %0d expected 0 1 0", busy, start_ready, coef_addr);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) seen = 1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_noresult: res_valid seen %b expected 0", seen);
        end
        coef_mem[0] = 16'd3;
        exp_q.push_back(16'h000C);
        abort = 1;
        start_cmd(1, 6'd0, 0, 0, 0);
        abort = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL start_over_abort: busy %b expected 1", busy);
        end
        feed('{16'd4, 0, 0, 0, 0, 0, 0, 0}, 1, 0);
        wait_result(got);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res_data !== exp) begin
            errors++; $display("FAIL abort_next: got %h valid %b expected %h", res_data, got, exp);
        end
        ack();
    endtask

    task automatic test_reset_mid;
        start_cmd(4, 6'd3, 0, 1, 1);
        feed('{16'd1, 16'd2, 0, 0, 0, 0, 0, 0}, 2, 0);
        #2 rstn = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ctrl: busy %b start_ready %b op_ready %b valid %b expected 0 1 0 0", busy, start_ready, op_ready, res_valid);
        end
        checks++;
        if (mac_out_sel !== 6'd0 || mac_tc !== 1'b0 || mac_acc_sat !== 1'b0 || res_data !== 16'h0) begin
            errors++; $display("FAIL reset_mid_cfg: out_sel %0d tc %b sat %b data %h expected 0 0 0 0", mac_out_sel, mac_tc, mac_acc_sat, res_data);
        end
        @(negedge clk) rstn = 1;
        tick();
    endtask

    task automatic test_back_to_back;
        bit got; int n, prev_n, s, prev_s; logic [5:0] os; logic t;
        logic [15:0] ops[8], cf[8], exp; logic [39:0] a;
        res_ready = 1;
        prev_n = 0; prev_s = 0;
        for (int c = 0; c < 4; c++) begin
            n = $urandom_range(1, 8); os = 6'($urandom_range(0, 24)); t = 1'($urandom_range(0, 1));
            a = '0;
            for (int k = 0; k < 8; k++) begin
                ops[k] = 16'($urandom); cf[k] = 16'($urandom);
                if (k < n) a = a + mul(ops[k], cf[k], t);
            end
            set_coef(cf);
            exp_q.push_back(sel_out(a, os, 1'b0, t));
            s = cyc;
            start_cmd(n, os, 0, 0, t);
            feed(ops, n, 0);
            wait_result(got);
            exp = exp_q.pop_front();
            checks++;
            if (!got || res_data !== exp) begin
                errors++; $display("FAIL b2b_result%0d: got %h valid %b expected %h", c, res_data, got, exp);
            end
            if (c > 0) begin
                checks++;
                if (s - prev_s != prev_n + 3) begin
                    errors++; $display("FAIL b2b_period%0d: got %0d expected %0d", c, s - prev_s, prev_n + 3);
                end
            end
            prev_n = n; prev_s = s;
            tick();
        end
        res_ready = 0;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_round();
        test_sat();
        test_bubbles();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the 16-bit eFPGA math-block MAC. It runs one N-tap dot product per command:
- takes operands from a valid/ready stream;
- reads coefficients from a synchronous 1-cycle-latency coefficient RAM;
- drives the MAC control pins (clear/round preload, clock enable, output select, saturation, two's-complement);
- returns the final 16-bit MAC output on a result handshake.

It sits beside the MAC in the math-unit wrapper. The parent wires it to the MAC and to the coefficient RAM.

## Interface
Parameters:
- NTAP_W, 6, tap index width; taps per command 1..2^NTAP_W; legal range 1..8, which keeps the 40-bit accumulator overflow-free.

Ports:
- MAC_ACC_CLK  in  1  clock
- acc_ff_rstn  in  1  reset, asynchronous, active-low
- start  in  1  command request
- start_ready  out  1  command accept; high only in IDLE
- len_m1  in  NTAP_W  tap count minus one
- out_sel  in  6  accumulator output bit offset, 0..24
- rnd_en  in  1  round-half preload on first tap
- sat_en  in  1  saturate result
- tc  in  1  signed operands
- abort  in  1  synchronous cancel
- op_valid / op_ready  in / out  1  operand stream handshake
- op_data  in  16  operand
- coef_addr  out  NTAP_W  coefficient RAM read address
- coef_rdata  in  16  RAM data for the address presented on the previous cycle
- mac_oper_data, mac_coef_data  out  16  to MAC operand/coefficient
- mac_clk_en, mac_acc_clear, mac_acc_rnd, mac_acc_sat, mac_tc  out  1  to MAC
- mac_out_sel  out  6  to MAC
- mac_out  in  16  from MAC
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  16  result
- busy  out  1  state != IDLE

## Operation
- Reset values:
  - state IDLE, tap=0.
  - All config registers 0.
  - res_data=0, res_valid=0, op_ready=0, mac_clk_en=0, clear=0, rnd=0, busy=0.
  - start_ready=1, coef_addr=0.
- Config latch: len_m1, out_sel, rnd_en, sat_en and tc are latched on start&start_ready.
- Config drive: mac_out_sel, mac_acc_sat and mac_tc come from the latched registers in every state, so the MAC's internal out-select register stays stable across a command and the result capture.
- Data pass-through: mac_oper_data=op_data; mac_coef_data=coef_rdata.
- coef_addr = next value of tap (combinational). In IDLE it is 0, so coef_rdata already equals coef[0] in the first RUN cycle; there are no prefetch bubbles.
- States:
  - IDLE: start → RUN.
  - RUN:
    - op_ready=1 and mac_clk_en=op_valid.
    - On tap==0: mac_acc_clear=~rnd_en and mac_acc_rnd=rnd_en.
    - On op_valid: tap++. If tap==len_m1, go to CAPT instead and reset tap to 0.
    - op_valid low: nothing enabled, tap holds, coef_addr holds.
  - CAPT: one cycle; mac_out is now final; res_data<=mac_out.
  - RESULT: res_valid=1; res_data stable until res_ready; res_ready → IDLE.
- abort: from any non-IDLE state, go to IDLE next edge, tap=0, no result.
  - Accumulator contents are left as-is; the next command's first tap clears them.
  - An abort in the same cycle as an operand accept still consumes that operand (op_ready is already high).
- Arithmetic (products, saturation, rounding constant) belongs entirely to the MAC. The controller never alters data.

## Timing
- T0: start accepted. T1: first RUN cycle.
- With op_valid held high, tap k is consumed at T1+k and the last tap at T1+len_m1.
- CAPT at T1+len_m1+1; res_valid from T1+len_m1+2.
- Minimum command period with res_ready high: len_m1+4 cycles (includes the IDLE cycle).
- Operand bubbles add exactly one cycle each.
- start is ignored outside IDLE. start and abort together in IDLE: start wins.
- Reset mid-command: immediate return to reset values. The MAC accumulator is reset by the same net.

## Structure
- Shared package mac_ctrl_pkg holds:
  - state enum (IDLE, RUN, CAPT, RESULT);
  - OUT_SEL_MAX=24;
  - default NTAP_W.
- No sub-module. The MAC and coefficient RAM are instantiated by the parent.

## Test plan
- Unsigned, 4 taps (len_m1=3), out_sel=0, operands 1,2,3,4, coefficients 5,6,7,8 → res_data=0x0046, res_valid at T1+5.
- Signed: tc=1, 2 taps, operands 0xFFFF,0xFFFE, coefficients 3,3, out_sel=0 → 0xFFF7.
- Rounding: same signed case with rnd_en=1 and out_sel=1 → 0xFFFC. Exactly one cycle with mac_acc_rnd=1 and none with clear.
- Saturation:
  - sat_en=1, tc=0, 2 taps of 0xFFFF×0xFFFF, out_sel=0 → 0xFFFF.
  - With tc=1 and operands 0x7FFF×0x7FFF → 0x7FFF.
- Handshake:
  - op_valid toggled every other cycle → tap count and result unchanged.
  - res_ready held low 5 cycles → res_data stable, start_ready low.
- abort asserted at tap 2 of 8 → IDLE next cycle, no res_valid. A following 1-tap command 3×4 → 0x000C, proving the first-tap clear.
